fft_sdf_stage_ctrl: RTL and testbench
=====================================

# fft_sdf_stage_ctrl

Sequencing controller for one single-path delay-feedback (SDF) radix-2 FFT stage. It owns the stage's feedback delay line, counts samples within a 2·DELAY frame, and drives the butterfly's 2-bit mode input, its two operands and the twiddle ROM address. It also handles input stalls, back-to-back frames and end-of-stream draining. One instance sits between consecutive stages of the FFT accelerator's stage chain, wrapped around one external butterfly instance.

## Interface
Parameters:
- DELAY, 32: delay-line depth (N/2 of this stage); power of two, ≥2
- TW_AW, 5: twiddle ROM address width
- TW_STRIDE, 1: twiddle index multiplier for this stage

Ports:
- clk  in  1  stage clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample present on din
- in_ready  out  1  sample accepted when in_valid && in_ready
- din_r, din_i  in  24 each  signed input sample
- bf_state  out  2  butterfly mode: 00 fill, 01 sum/diff, 10 rotate, 11 idle
- bf_a_r, bf_a_i  out  24 each  delay-line head to butterfly operand A
- bf_b_r, bf_b_i  out  24 each  din to butterfly operand B
- bf_delay_r, bf_delay_i  in  24 each  butterfly value to push into the delay line
- bf_op_r, bf_op_i  in  24 each  butterfly result
- bf_outvalid  in  1  butterfly result valid
- tw_addr  out  TW_AW  twiddle ROM address (ROM read is combinational)
- dout_r, dout_i  out  24 each  stage output, equal to bf_op
- out_valid  out  1  equal to bf_outvalid
- out_sof  out  1  first output of a frame
- err  out  1  sticky streaming-underrun flag

## Operation
- Advance strobe `adv`: one delay-line shift plus one counter increment. k is the index within the current half, 0..DELAY-1; it wraps to 0 at every half boundary.
- FILL (bf_state 00): in_ready=1. adv=in_valid. Each accepted sample is pushed into the delay line (butterfly passes din_b to delay). Once DELAY samples are accepted, go to BFLY.
- BFLY (bf_state 01 when in_valid, 11 when stalled): in_ready=1. adv=in_valid. The butterfly outputs A+B and pushes A−B. out_sof=1 on the k=0 advance. After DELAY samples, go to ROT.
- ROT (bf_state 10): adv=1 every cycle, with no stall. tw_addr=(k·TW_STRIDE) mod 2^TW_AW. The butterfly outputs head·W and pushes din. The sub-mode is latched on the first ROT cycle:
  - If in_valid=1 on that cycle, the sub-mode is STREAM. in_ready=1 for the whole half, din is accepted as the next frame's first half, and the state goes to BFLY at the end of the half.
  - If in_valid=0 on that cycle, the sub-mode is DRAIN. in_ready=0 for the rest of the half, the pushed data is don't-care, and the state goes to FILL at the end of the half.
- STREAM underrun: in_valid=0 on any STREAM cycle after the first sets err (sticky until reset). The cycle still advances and pushes garbage.
- tw_addr=0 outside ROT.
- bf_a is always the delay-line head (oldest entry). bf_b is always din.
- No arithmetic is performed here. Widths pass through at 24 bits.

## Timing
- Reset (asynchronous, mid-frame included): state=FILL, k=0, sub-mode cleared, err=0, out_sof=0, in_ready=1, bf_state=00, tw_addr=0. Delay-line contents are not reset.
- All outputs are combinational from registered state plus din/in_valid. There are no combinational paths from bf_* inputs to in_ready.
- Butterfly latency is 0: dout follows the accepting cycle.
- The first valid output appears DELAY accepted samples after the first frame starts.
- Frame output order: DELAY sums (BFLY), then DELAY rotated differences (ROT).
- With continuous input, throughput is 1 sample per cycle and there are no bubbles between frames.
- Wrap-around: k=DELAY-1 with adv causes the state change on that clock edge.

## Structure
- Package fft_pkg: bf_state encodings BF_FILL=2'b00, BF_SUM=2'b01, BF_ROT=2'b10, BF_IDLE=2'b11; the sample width constant 24; the controller state enum FILL/BFLY/ROT.
- Sub-module sdf_delay_line (parameter DEPTH, 48-bit wide): shift-enable FIFO of fixed depth. The head is the entry written DEPTH shifts ago. Implemented as a circular buffer with a single pointer; no reset on storage.

## Test plan
Common bench setup: DELAY=4, TW_STRIDE=1, an ideal butterfly model, and a ROM returning W=(256,0) (1.0 in Q8) unless stated otherwise.
- Single frame: inputs 1..8 (imag 0) continuous, then in_valid=0. Expect dout 6,8,10,12 (out_sof on 6), then −4,−4,−4,−4 during the DRAIN half. in_ready=0 for DRAIN cycles 2–4. err=0.
- Back-to-back: frames 1..8 then 11..18 continuous. Expect second-frame sums 26,28,30,32 immediately after ROT, with no idle cycle. tw_addr sequence 0,1,2,3 in each ROT.
- Stalls: in_valid low for 2 cycles between samples 2–3 and again between 6–7. Expect bf_state=11 and out_valid=0 only during the BFLY stall; outputs are identical to the single-frame case.
- Underrun: drop in_valid on the 3rd STREAM cycle. Expect err=1 from the next cycle and held until rst_n. ROT still completes in 4 cycles.
- Twiddle: ROM returns W=(0,−256) at addr 2 (for the ideal butterfly model, multiplication by −j). Single frame with inputs 1,0,2,0,0,0,0,0. Expect the third ROT output to equal (0,−2).
- Reset mid-BFLY at k=2: after release, expect bf_state=00, tw_addr=0, in_ready=1. A fresh frame 1..8 must reproduce the single-frame outputs.

Source files
------------

// File: rtl/fft_pkg.sv
//------------------------------------------------------------------------------
// fft_pkg : shared encodings and types for the SDF FFT stage controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

    localparam int SAMPLE_W = 24;

    localparam logic [1:0] BF_FILL = 2'b00;
    localparam logic [1:0] BF_SUM  = 2'b01;
    localparam logic [1:0] BF_ROT  = 2'b10;
    localparam logic [1:0] BF_IDLE = 2'b11;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        BFLY = 2'd1,
        ROT  = 2'd2
    } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/sdf_delay_line.sv
//------------------------------------------------------------------------------
// sdf_delay_line : fixed-depth shift-enable delay line as a circular buffer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sdf_delay_line
    import fft_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    shift_i,
    input  logic [2*SAMPLE_W-1:0]   din_i,
    output logic [2*SAMPLE_W-1:0]   head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2*SAMPLE_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]         ptr_q;
    logic [PW-1:0]         ptr_d;

    // The slot about to be overwritten is the one written DEPTH shifts ago.
    assign head_o = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (shift_i) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fft_sdf_stage_ctrl.sv
//------------------------------------------------------------------------------
// fft_sdf_stage_ctrl : sequencing controller for one radix-2 SDF FFT stage
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fft_sdf_stage_ctrl
    import fft_pkg::*;
#(
    parameter int DELAY     = 32,
    parameter int TW_AW     = 5,
    parameter int TW_STRIDE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] din_r,
    input  logic [SAMPLE_W-1:0] din_i,
    output logic [1:0]          bf_state,
    output logic [SAMPLE_W-1:0] bf_a_r,
    output logic [SAMPLE_W-1:0] bf_a_i,
    output logic [SAMPLE_W-1:0] bf_b_r,
    output logic [SAMPLE_W-1:0] bf_b_i,
    input  logic [SAMPLE_W-1:0] bf_delay_r,
    input  logic [SAMPLE_W-1:0] bf_delay_i,
    input  logic [SAMPLE_W-1:0] bf_op_r,
    input  logic [SAMPLE_W-1:0] bf_op_i,
    input  logic                bf_outvalid,
    output logic [TW_AW-1:0]    tw_addr,
    output logic [SAMPLE_W-1:0] dout_r,
    output logic [SAMPLE_W-1:0] dout_i,
    output logic                out_valid,
    output logic                out_sof,
    output logic                err
);

    localparam int KW = $clog2(DELAY);

    ctrl_state_t   state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          stream_q, stream_d;
    logic          err_q, err_d;

    logic          adv;
    logic          stream_now;
    logic          last_k;
    logic [2*SAMPLE_W-1:0] head;

    assign last_k = (k_q == KW'(DELAY - 1));

    sdf_delay_line #(
        .DEPTH (DELAY)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_i (adv),
        .din_i   ({bf_delay_r, bf_delay_i}),
        .head_o  (head)
    );

    assign bf_a_r    = head[2*SAMPLE_W-1:SAMPLE_W];
    assign bf_a_i    = head[SAMPLE_W-1:0];
    assign bf_b_r    = din_r;
    assign bf_b_i    = din_i;
    assign dout_r    = bf_op_r;
    assign dout_i    = bf_op_i;
    assign out_valid = bf_outvalid;
    assign err       = err_q;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        stream_d   = stream_q;
        err_d      = err_q;
        adv        = 1'b0;
        stream_now = stream_q;
        in_ready   = 1'b1;
        bf_state   = BF_FILL;
        out_sof    = 1'b0;
        tw_addr    = '0;

        case (state_q)
            FILL: begin
                adv      = in_valid;
                bf_state = BF_FILL;
            end
            BFLY: begin
                adv      = in_valid;
                bf_state = in_valid ? BF_SUM : BF_IDLE;
                out_sof  = in_valid && (k_q == '0);
            end
            ROT: begin
                adv      = 1'b1;
                bf_state = BF_ROT;
                tw_addr  = TW_AW'(k_q) * TW_AW'(TW_STRIDE);
                // Sub-mode is decided by in_valid on the first cycle of the half.
                if (k_q == '0) begin
                    stream_d   = in_valid;
                    stream_now = in_valid;
                end else begin
                    in_ready = stream_q;
                    if (stream_q && !in_valid) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (adv) begin
            k_d = last_k ? '0 : k_q + KW'(1);
            if (last_k) begin
                case (state_q)
                    FILL:    state_d = BFLY;
                    BFLY:    state_d = ROT;
                    ROT:     state_d = stream_now ? BFLY : FILL;
                    default: state_d = FILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            k_q      <= '0;
            stream_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            stream_q <= stream_d;
            err_q    <= err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_sdf_stage_ctrl.sv
//------------------------------------------------------------------------------
// tb_fft_sdf_stage_ctrl : directed bench with ideal butterfly and twiddle ROM
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fft_sdf_stage_ctrl;

    localparam int DELAY = 4;
    localparam int TW_AW = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [23:0]  din_r = '0, din_i = '0;
    logic [1:0]          bf_state;
    logic signed [23:0]  bf_a_r, bf_a_i, bf_b_r, bf_b_i;
    logic signed [23:0]  bf_delay_r, bf_delay_i, bf_op_r, bf_op_i;
    logic                bf_outvalid;
    logic [TW_AW-1:0]    tw_addr;
    logic signed [23:0]  dout_r, dout_i;
    logic                out_valid, out_sof, err;

    always #5 clk = ~clk;

    fft_sdf_stage_ctrl #(
        .DELAY     (DELAY),
        .TW_AW     (TW_AW),
        .TW_STRIDE (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din_r       (din_r),
        .din_i       (din_i),
        .bf_state    (bf_state),
        .bf_a_r      (bf_a_r),
        .bf_a_i      (bf_a_i),
        .bf_b_r      (bf_b_r),
        .bf_b_i      (bf_b_i),
        .bf_delay_r  (bf_delay_r),
        .bf_delay_i  (bf_delay_i),
        .bf_op_r     (bf_op_r),
        .bf_op_i     (bf_op_i),
        .bf_outvalid (bf_outvalid),
        .tw_addr     (tw_addr),
        .dout_r      (dout_r),
        .dout_i      (dout_i),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .err         (err)
    );

    // Twiddle ROM: W = 1.0 in Q8, or -j at address 2 when rom_mode is set.
    logic               rom_mode = 1'b0;
    logic signed [23:0] w_r, w_i;
    always_comb begin
        w_r = 24'sd256;
        w_i = 24'sd0;
        if (rom_mode && tw_addr == 5'd2) begin
            w_r = 24'sd0;
            w_i = -24'sd256;
        end
    end

    // Ideal zero-latency butterfly.
    longint pr, pi;
    always_comb begin
        bf_delay_r  = bf_b_r;
        bf_delay_i  = bf_b_i;
        bf_op_r     = '0;
        bf_op_i     = '0;
        bf_outvalid = 1'b0;
        pr          = 0;
        pi          = 0;
        case (bf_state)
            2'b01: begin
                bf_op_r     = bf_a_r + bf_b_r;
                bf_op_i     = bf_a_i + bf_b_i;
                bf_delay_r  = bf_a_r - bf_b_r;
                bf_delay_i  = bf_a_i - bf_b_i;
                bf_outvalid = 1'b1;
            end
            2'b10: begin
                pr = longint'(bf_a_r) * longint'(w_r) - longint'(bf_a_i) * longint'(w_i);
                pi = longint'(bf_a_r) * longint'(w_i) + longint'(bf_a_i) * longint'(w_r);
                bf_op_r     = 24'(pr >>> 8);
                bf_op_i     = 24'(pi >>> 8);
                bf_outvalid = 1'b1;
            end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    int o_r[$], o_i[$], o_sof[$], o_tw[$];
    int e_r[$], e_i[$], e_sof[$];
    int s_ready, s_state, s_err, s_valid;

    task automatic clear_q();
        o_r.delete(); o_i.delete(); o_sof.delete(); o_tw.delete();
        e_r.delete(); e_i.delete(); e_sof.delete();
    endtask

    // One clock cycle: drive, sample mid-cycle, then advance past the edge.
    task automatic step(input logic v, input int r, input int i);
        in_valid = v;
        din_r    = 24'(r);
        din_i    = 24'(i);
        #3;
        s_ready = int'(in_ready);
        s_state = int'(bf_state);
        s_err   = int'(err);
        s_valid = int'(out_valid);
        if (out_valid) begin
            o_r.push_back(int'(dout_r));
            o_i.push_back(int'(dout_i));
            o_sof.push_back(int'(out_sof));
        end
        if (bf_state == 2'b10) o_tw.push_back(int'(tw_addr));
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int first, input int n);
        for (int j = 0; j < n; j++) step(1'b1, first + j, 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic expect_frame(input int s0, input int s1, input int s2, input int s3,
                                input int d);
        e_r.push_back(s0); e_r.push_back(s1); e_r.push_back(s2); e_r.push_back(s3);
        for (int j = 0; j < 4; j++) e_r.push_back(d);
        for (int j = 0; j < 8; j++) begin
            e_i.push_back(0);
            e_sof.push_back(j == 0 ? 1 : 0);
        end
    endtask

    task automatic cmp_out(input string tag);
        chk({tag, "_count"}, o_r.size(), e_r.size());
        for (int j = 0; j < e_r.size() && j < o_r.size(); j++) begin
            chk($sformatf("%s_re%0d", tag, j), o_r[j], e_r[j]);
            chk($sformatf("%s_im%0d", tag, j), o_i[j], e_i[j]);
            chk($sformatf("%s_sof%0d", tag, j), o_sof[j], e_sof[j]);
        end
    endtask

    task automatic drain4(input string tag);
        step(1'b0, 0, 0); chk({tag, "_rdy1"}, s_ready, 1);
        step(1'b0, 0, 0); chk({tag, "_rdy2"}, s_ready, 0);
        step(1'b0, 0, 0); chk({tag, "_rdy3"}, s_ready, 0);
        step(1'b0, 0, 0); chk({tag, "_rdy4"}, s_ready, 0);
    endtask

    int rot_cycles;

    initial begin
        // Reset state
        #2;
        chk("rst_bfstate", int'(bf_state), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_tw", int'(tw_addr), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_sof", int'(out_sof), 0);
        do_reset();

        // Single frame followed by drain
        feed(1, 8);
        drain4("single");
        step(1'b0, 0, 0);
        chk("single_back_fill", s_state, 0);
        chk("single_err", s_err, 0);
        expect_frame(6, 8, 10, 12, -4);
        cmp_out("single");
        chk("single_tw_n", o_tw.size(), 4);
        for (int j = 0; j < 4 && j < o_tw.size(); j++) chk($sformatf("single_tw%0d", j), o_tw[j], j);

        // Back-to-back frames
        do_reset();
        feed(1, 8);
        feed(11, 8);
        drain4("b2b");
        expect_frame(6, 8, 10, 12, -4);
        expect_frame(26, 28, 30, 32, -4);
        cmp_out("b2b");
        chk("b2b_tw_n", o_tw.size(), 8);
        for (int j = 0; j < 8 && j < o_tw.size(); j++) chk($sformatf("b2b_tw%0d", j), o_tw[j], j % 4);

        // Stalls in FILL and BFLY
        do_reset();
        feed(1, 2);
        step(1'b0, 0, 0); chk("stall_fill_state", s_state, 0);
        step(1'b0, 0, 0);
        feed(3, 4);
        step(1'b0, 0, 0);
        chk("stall_bfly_state1", s_state, 3);
        chk("stall_bfly_valid1", s_valid, 0);
        step(1'b0, 0, 0);
        chk("stall_bfly_state2", s_state, 3);
        chk("stall_bfly_valid2", s_valid, 0);
        feed(7, 2);
        drain4("stall");
        expect_frame(6, 8, 10, 12, -4);
        cmp_out("stall");

        // Streaming underrun on the third ROT cycle
        do_reset();
        feed(1, 8);
        rot_cycles = 0;
        step(1'b1, 11, 0); chk("ur_err_c1", s_err, 0); rot_cycles += (s_state == 2) ? 1 : 0;
        step(1'b1, 12, 0); chk("ur_err_c2", s_err, 0); rot_cycles += (s_state == 2) ? 1 : 0;
        step(1'b0, 0, 0);  chk("ur_err_c3", s_err, 0); rot_cycles += (s_state == 2) ? 1 : 0;
        step(1'b1, 14, 0); chk("ur_err_c4", s_err, 1); rot_cycles += (s_state == 2) ? 1 : 0;
        chk("ur_rot_cycles", rot_cycles, 4);
        step(1'b0, 0, 0);
        chk("ur_after_state", s_state, 3);
        chk("ur_err_hold1", s_err, 1);
        repeat (3) step(1'b0, 0, 0);
        chk("ur_err_hold2", s_err, 1);
        do_reset();
        #1;
        chk("ur_err_cleared", int'(err), 0);

        // Twiddle of -j at address 2
        do_reset();
        rom_mode = 1'b1;
        step(1'b1, 1, 0); step(1'b1, 0, 0); step(1'b1, 2, 0); step(1'b1, 0, 0);
        feed(0, 1); feed(0, 1); feed(0, 1); feed(0, 1);
        drain4("tw");
        rom_mode = 1'b0;
        e_r = '{1, 0, 2, 0, 1, 0, 0, 0};
        e_i = '{0, 0, 0, 0, 0, 0, -2, 0};
        e_sof = '{1, 0, 0, 0, 0, 0, 0, 0};
        cmp_out("tw");

        // Asynchronous reset in BFLY at k=2
        do_reset();
        feed(1, 6);
        in_valid = 1'b1;
        din_r    = 24'sd7;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_bfstate", int'(bf_state), 0);
        chk("mrst_tw", int'(tw_addr), 0);
        chk("mrst_ready", int'(in_ready), 1);
        chk("mrst_sof", int'(out_sof), 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
        feed(1, 8);
        drain4("mrst");
        expect_frame(6, 8, 10, 12, -4);
        cmp_out("mrst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
